plug_cfg_ctrl: RTL
==================

Name: plug_cfg_ctrl

Overview:
Sequencing controller for the plugboard pair storage. It accepts a stream of keyed letters, validates them, and pairs consecutive letters. Each valid pair is committed into the lowest free plug slot, and the per-slot active mask and pair words feed the plugboard swap logic. CFG_BUSY stalls the encryption path while a pair is half-entered or being committed.

Parameters:
NUM_PAIRS, 4, number of plug slots (1..10)
NUM_LETTERS, 26, legal letter codes 0..NUM_LETTERS-1; codes >= NUM_LETTERS are invalid

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous, active-low reset
KEY_VLD  in  1  letter offered this cycle
KEY_RDY  out  1  controller can accept a letter; transfer when KEY_VLD&&KEY_RDY
KEY_LET  in  5  offered letter code
CLR  in  1  single-cycle request to wipe all pairs
ACT  out  NUM_PAIRS  slot i holds a valid pair
PAIR  out  NUM_PAIRS x 10  slot i pair: [9:5] first letter, [4:0] second letter
USED  out  26  bit n set when letter n is plugged in any active slot
CFG_BUSY  out  1  high in every state except IDLE
ERR  out  1  one-cycle pulse on a rejected letter or pair
ERR_CODE  out  2  held until next ERR: 0 invalid letter, 1 already plugged, 2 self-pair, 3 slots full

Behaviour:
- Reset (async on RST_N low): state=IDLE; ACT=0; PAIR=0; USED=0; ERR=0; ERR_CODE=0; pending letter=0; KEY_RDY=1; CFG_BUSY=0.
- States: IDLE, FIRST, CHECK, COMMIT, CLEAR.
- IDLE, on transfer:
  - letter >= NUM_LETTERS: ERR code 0, stay in IDLE.
  - USED[letter] set: ERR code 1, stay in IDLE (deletion variant below).
  - ACT all ones: ERR code 3, stay in IDLE.
  - otherwise latch the letter as pending and go to FIRST.
- FIRST, on transfer:
  - invalid letter: ERR code 0, stay in FIRST (pending kept).
  - letter == pending: ERR code 2, return to IDLE and drop pending.
  - USED[letter] set: ERR code 1, return to IDLE.
  - otherwise latch the second letter and go to CHECK.
- CHECK: KEY_RDY=0. Compute the lowest free slot. Go to COMMIT.
- COMMIT: KEY_RDY=0. On the exit edge, write PAIR[slot]={pending,second}, set ACT[slot], set both USED bits. Go to IDLE.
- Latency: second-letter accept at edge t; ACT/PAIR/USED visible after edge t+2; KEY_RDY high again after edge t+2.
- CLR: highest priority in any state. Next state is CLEAR and any pending letter is discarded.
  - In CLEAR: KEY_RDY=0. On the exit edge, zero ACT, PAIR and USED, then go to IDLE.
  - A simultaneous KEY_VLD on the CLR cycle is not accepted, because KEY_RDY is forced low whenever CLR=1.
- ERR: asserted exactly one cycle after the rejecting edge. Back-to-back rejects give back-to-back pulses.
- USED is a register updated in COMMIT/CLEAR/delete. It must always equal the OR of the decoded letters of active slots.
- Slot allocation picks the lowest index with ACT=0. Order is deterministic so slot numbers are reproducible.
- CFG_BUSY = (state != IDLE). Encryption must not sample PAIR while CFG_BUSY=1.

Optional Feature:
PLUG_DELETE_EN
- Defined: in IDLE, a transfer of a letter with USED set removes the whole pair containing it. The slot's ACT and PAIR are cleared and both USED bits drop after the accepting edge. No ERR is raised.
- In FIRST the behaviour is unchanged (ERR code 1).
- Undefined: this case is ERR code 1, as listed above.

Decomposition:
- Package plug_cfg_pkg holds:
  - letter_t (logic [4:0]);
  - pair_t packed struct {letter_t a, b};
  - NUM_LETTERS_C=26;
  - ERR code constants;
  - cfg_state_t enum.
- Sub-module plug_slot_alloc: combinational priority encoder from ACT to {free_idx, full}; also used for the delete-slot lookup by letter match.

Test Plan:
- Reset, then key 0 then 4 (A,E) -> after 2 further edges ACT=0001, PAIR[0]=10'b00000_00100, USED bits 0 and 4 set, CFG_BUSY high for 3 cycles.
- Fill 4 pairs (A-E, B-F, C-G, D-H), then key 9 -> ERR=1, ERR_CODE=3, state stays IDLE, ACT=1111.
- Key 10 then 10 -> ERR_CODE=2, back to IDLE, ACT unchanged; key 30 -> ERR_CODE=0.
- With pair A-E stored, key 2 then 4 -> ERR_CODE=1 on the second letter, USED[2] stays 0.
- Key 1, then CLR on the same cycle as KEY_VLD with letter 3 -> KEY_RDY=0, letter not taken; after CLEAR, ACT=0 and USED=0.
- PLUG_DELETE_EN: pairs in slots 0-1, key 4 -> slot 0 cleared; next pair 7-8 lands in slot 0. Without the macro, the same key 4 gives ERR_CODE=1.

Source files
------------

// File: rtl/plug_cfg_pkg.sv
// Shared types and constants for the plugboard pair configuration controller.
package plug_cfg_pkg;

    typedef logic [4:0] letter_t;

    typedef struct packed {
        letter_t a;
        letter_t b;
    } pair_t;

    localparam int NUM_LETTERS_C = 26;

    localparam logic [1:0] ERR_INVALID = 2'd0;
    localparam logic [1:0] ERR_PLUGGED = 2'd1;
    localparam logic [1:0] ERR_SELF    = 2'd2;
    localparam logic [1:0] ERR_FULL    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_CLEAR  = 3'd4
    } cfg_state_t;

    // Slot index width; one bit minimum so a single-slot build still has an index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot mask of a letter within the 26-bit USED vector.
    function automatic logic [25:0] letter_mask(input letter_t l);
        return 26'(32'd1 << l);
    endfunction

endpackage

// File: rtl/plug_slot_alloc.sv
// Combinational slot lookup: lowest free slot (with full flag) and the
// lowest active slot whose pair contains a given letter.
module plug_slot_alloc
    import plug_cfg_pkg::*;
#(
    parameter int NUM_PAIRS = 4,
    parameter int IDX_W     = idx_width(NUM_PAIRS)
) (
    input  logic [NUM_PAIRS-1:0]    i_act,
    input  logic [NUM_PAIRS*10-1:0] i_pair,
    input  logic [4:0]              i_letter,
    output logic [IDX_W-1:0]        o_free_idx,
    output logic                    o_full,
    output logic [IDX_W-1:0]        o_match_idx,
    output logic                    o_match
);

    pair_t w_p;

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        o_free_idx  = '0;
        o_full      = 1'b1;
        o_match_idx = '0;
        o_match     = 1'b0;
        w_p         = '0;
        for (int i = NUM_PAIRS - 1; i >= 0; i--) begin
            w_p = i_pair[i*10 +: 10];
            if (!i_act[i]) begin
                o_free_idx = IDX_W'(i);
                o_full     = 1'b0;
            end
            if (i_act[i] && ((w_p.a == i_letter) || (w_p.b == i_letter))) begin
                o_match_idx = IDX_W'(i);
                o_match     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plug_cfg_ctrl.sv
// Plugboard pair sequencing controller. Accepts keyed letters, validates
// them, pairs consecutive letters and commits each pair to the lowest free
// slot. Optional macro PLUG_DELETE_EN: keying an already-plugged letter in
// IDLE removes its pair instead of raising an error.
//
// Handshake: a letter transfers on a rising edge where KEY_VLD && KEY_RDY.
// KEY_RDY is high only in IDLE/FIRST and is forced low whenever CLR=1.
module plug_cfg_ctrl
    import plug_cfg_pkg::*;
#(
    parameter int NUM_PAIRS   = 4,
    parameter int NUM_LETTERS = NUM_LETTERS_C
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    KEY_VLD,
    output logic                    KEY_RDY,
    input  logic [4:0]              KEY_LET,
    input  logic                    CLR,
    output logic [NUM_PAIRS-1:0]    ACT,
    output logic [NUM_PAIRS*10-1:0] PAIR,
    output logic [25:0]             USED,
    output logic                    CFG_BUSY,
    output logic                    ERR,
    output logic [1:0]              ERR_CODE,
    output logic [2:0]              DBG_STATE
);

    localparam int IDX_W = idx_width(NUM_PAIRS);

    cfg_state_t              r_state;
    cfg_state_t              w_next;
    letter_t                 r_pend;
    letter_t                 r_second;
    logic [IDX_W-1:0]        r_slot;
    logic [NUM_PAIRS-1:0]    r_act;
    logic [NUM_PAIRS*10-1:0] r_pair;
    logic [25:0]             r_used;
    logic                    r_err;
    logic [1:0]              r_err_code;

    logic                    w_key_rdy;
    logic                    w_xfer;
    logic                    w_valid;
    logic                    w_used_hit;
    logic                    w_rej;
    logic [1:0]              w_rej_code;
    logic                    w_latch_pend;
    logic                    w_latch_sec;
    logic                    w_del;
    logic [IDX_W-1:0]        w_free_idx;
    logic                    w_full;
    logic [IDX_W-1:0]        w_match_idx;
    logic                    w_match;
    pair_t                   w_del_pair;

    assign w_key_rdy  = ((r_state == ST_IDLE) || (r_state == ST_FIRST)) && !CLR;
    assign w_xfer     = KEY_VLD && w_key_rdy;
    assign w_valid    = ({27'd0, KEY_LET} < 32'(NUM_LETTERS));
    assign w_used_hit = w_valid && (|(letter_mask(KEY_LET) & r_used));
    assign w_del_pair = r_pair[w_match_idx*10 +: 10];

    plug_slot_alloc #(
        .NUM_PAIRS (NUM_PAIRS),
        .IDX_W     (IDX_W)
    ) u_alloc (
        .i_act       (r_act),
        .i_pair      (r_pair),
        .i_letter    (KEY_LET),
        .o_free_idx  (w_free_idx),
        .o_full      (w_full),
        .o_match_idx (w_match_idx),
        .o_match     (w_match)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode plus the per-cycle reject/latch/delete strobes.
    always_comb begin
        w_next       = r_state;
        w_rej        = 1'b0;
        w_rej_code   = r_err_code;
        w_latch_pend = 1'b0;
        w_latch_sec  = 1'b0;
        w_del        = 1'b0;
        if (CLR) begin
            w_next = ST_CLEAR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        if (!w_valid) begin
                            w_rej      = 1'b1;
                            w_rej_code = ERR_INVALID;
                        end else if (w_used_hit) begin
`ifdef PLUG_DELETE_EN
                            w_del      = w_match;
`else
                            w_rej      = 1'b1;
                            w_rej_code = ERR_PLUGGED;
`endif
                        end else if (w_full) begin
                            w_rej      = 1'b1;
                            w_rej_code = ERR_FULL;
                        end else begin
                            w_latch_pend = 1'b1;
                            w_next       = ST_FIRST;
                        end
                    end
                end
                ST_FIRST: begin
                    if (w_xfer) begin
                        if (!w_valid) begin
                            w_rej      = 1'b1;
                            w_rej_code = ERR_INVALID;
                        end else if (KEY_LET == r_pend) begin
                            w_rej      = 1'b1;
                            w_rej_code = ERR_SELF;
                            w_next     = ST_IDLE;
                        end else if (w_used_hit) begin
                            w_rej      = 1'b1;
                            w_rej_code = ERR_PLUGGED;
                            w_next     = ST_IDLE;
                        end else begin
                            w_latch_sec = 1'b1;
                            w_next      = ST_CHECK;
                        end
                    end
                end
                ST_CHECK:  w_next = ST_COMMIT;
                ST_COMMIT: w_next = ST_IDLE;
                ST_CLEAR:  w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    // Datapath: pending letters, slot choice, pair storage and error reporting.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pend     <= '0;
            r_second   <= '0;
            r_slot     <= '0;
            r_act      <= '0;
            r_pair     <= '0;
            r_used     <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_INVALID;
        end else begin
            r_err <= w_rej;
            if (w_rej) r_err_code <= w_rej_code;

            // Pending letter is dropped whenever the sequence returns to IDLE.
            if (CLR || ((w_next == ST_IDLE) && (r_state != ST_IDLE))) r_pend <= '0;
            else if (w_latch_pend)                                     r_pend <= KEY_LET;

            if (w_latch_sec) r_second <= KEY_LET;
            if (r_state == ST_CHECK) r_slot <= w_free_idx;

            if (r_state == ST_CLEAR) begin
                r_act  <= '0;
                r_pair <= '0;
                r_used <= '0;
            end else if ((r_state == ST_COMMIT) && !CLR) begin
                r_act[r_slot]           <= 1'b1;
                r_pair[r_slot*10 +: 10] <= {r_pend, r_second};
                r_used <= r_used | letter_mask(r_pend) | letter_mask(r_second);
            end else if (w_del) begin
                r_act[w_match_idx]           <= 1'b0;
                r_pair[w_match_idx*10 +: 10] <= '0;
                r_used <= r_used & ~(letter_mask(w_del_pair.a) | letter_mask(w_del_pair.b));
            end
        end
    end

    assign KEY_RDY   = w_key_rdy;
    assign ACT       = r_act;
    assign PAIR      = r_pair;
    assign USED      = r_used;
    assign CFG_BUSY  = (r_state != ST_IDLE);
    assign ERR       = r_err;
    assign ERR_CODE  = r_err_code;
    assign DBG_STATE = r_state;

endmodule
